mem_bus_master: RTL and testbench

Command-driven initiator for the native iomem/mem bus (`valid`/`ready`/`addr`/`wdata`/`wstrb`/`rdata`), the counterpart to the memory-mapped peripherals such as the GPIO block. It accepts single or auto-incrementing burst commands from a local command stream and issues one bus transaction per beat. It returns one response per beat with backpressure. It sits between a debug or loader front-end and the SoC iomem bus.

---
 rtl/mem_bus_master.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: command-driven initiator for the native iomem bus.
// Takes single or auto-incrementing burst commands and issues one bus
// transaction per beat, returning one response per beat with backpressure.
// Optional feature: define MEM_BUS_MASTER_TIMEOUT_EN to abort beats whose
// mem_ready does not arrive within TIMEOUT_CYCLES cycles.
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    input  logic [7:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Reject out-of-range timeout settings at elaboration time.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_reg, state_next;
    logic        write_reg, write_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic        timeout_hit;
    logic        last_beat;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    // Terminal value is one less than the limit so mem_valid stays high
    // for exactly TIMEOUT_CYCLES cycles before the beat is abandoned.
    localparam logic [15:0] WAIT_TERM = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_reg, wait_next;

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_reg <= 16'd0;
        end else begin
            wait_reg <= wait_next;
        end
    end

    // Count stalled REQ cycles; held at zero elsewhere so every REQ starts fresh.
    always_comb begin
        wait_next = 16'd0;
        if (state_reg == REQ && !mem_ready) begin
            wait_next = wait_reg + 16'd1;
        end
    end

    // A same-cycle mem_ready takes priority over the terminal count.
    assign timeout_hit = (state_reg == REQ) && !mem_ready && (wait_reg == WAIT_TERM);
`else
    assign timeout_hit = 1'b0;
`endif

    assign last_beat = (cnt_reg == 8'd0) || err_reg;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            write_reg <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
            cnt_reg   <= 8'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Next-state and datapath updates for the IDLE -> REQ -> RSP beat loop.
    always_comb begin
        state_next = state_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    write_next = cmd_write;
                    addr_next  = cmd_addr;
                    wdata_next = cmd_wdata;
                    // Reads always present an all-zero strobe on the bus.
                    wstrb_next = cmd_write ? cmd_wstrb : 4'h0;
                    cnt_next   = cmd_len;
                    err_next   = 1'b0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    rdata_next = write_reg ? 32'd0 : mem_rdata;
                    err_next   = 1'b0;
                    state_next = RSP;
                end else if (timeout_hit) begin
                    rdata_next = 32'd0;
                    err_next   = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = cnt_reg - 8'd1;
                        addr_next  = addr_reg + 32'd4;
                        state_next = REQ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign mem_valid = (state_reg == REQ);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;
    assign rsp_valid = (state_reg == RSP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_last  = rsp_valid && last_beat;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed self-checking bench for mem_bus_master.
// A small responder answers each beat one cycle after mem_valid rises with
// data = addr ^ 0xA5A5A5A5, and logs every beat it sees.
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [7:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    int total;
    int bad;

    // Responder / monitor state.
    bit          resp_en;
    bit          prev_valid;
    int          valid_cycles;
    int          overlap_cycles;
    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_wstrb[$];

    mem_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder and beat logger, evaluated mid-cycle after outputs settle.
    always @(posedge clk) begin
        #2;
        if (resp_en && mem_valid && !mem_ready) begin
            mem_ready = 1'b1;
            mem_rdata = mem_addr ^ 32'hA5A5A5A5;
        end else begin
            mem_ready = 1'b0;
        end
        if (mem_valid && !prev_valid) begin
            q_addr.push_back(mem_addr);
            q_wdata.push_back(mem_wdata);
            q_wstrb.push_back(mem_wstrb);
        end
        if (mem_valid) valid_cycles++;
        if (mem_valid && rsp_valid) overlap_cycles++;
        prev_valid = mem_valid;
    end

    task automatic clear_log();
        q_addr.delete();
        q_wdata.delete();
        q_wstrb.delete();
        valid_cycles   = 0;
        overlap_cycles = 0;
    endtask

    // Present one command for a single cycle; caller is #1 after an edge in IDLE.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEADBEEF;
        cmd_wdata = 32'hDEADBEEF;
        cmd_wstrb = 4'hF;
        cmd_len   = 8'hFF;
    endtask

    // Wait (bounded) for a response, hold it for 'hold' cycles, then consume it.
    task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic er,
                            output logic ls, output bit got, output bit stable);
        got    = 1'b0;
        stable = 1'b1;
        rd     = 32'hx;
        er     = 1'bx;
        ls     = 1'bx;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (got) begin
            rd = rsp_rdata;
            er = rsp_err;
            ls = rsp_last;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er ||
                    rsp_last !== ls || mem_valid) stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_last, mem_valid, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {cmd_ready, rsp_valid, rsp_err, rsp_last, mem_valid, busy});
        end
        total++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'd0) begin
            bad++;
            $display("FAIL reset_data got %h want 0", {rsp_rdata, mem_addr, mem_wdata, mem_wstrb});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
        end
        $display("reset: cmd_ready=%b busy=%b", cmd_ready, busy);
    endtask

    task automatic test_single_write();
        logic [31:0] rd;
        logic er, ls;
        bit got, stable;
        clear_log();
        resp_en = 1'b1;
        send_cmd(1'b1, 32'h03000004, 32'h00000001, 4'hF, 8'd0);
        total++;
        if ({mem_valid, busy, cmd_ready} !== 3'b110) begin
            bad++;
            $display("FAIL wr_req_cycle got %b want 110", {mem_valid, busy, cmd_ready});
        end
        @(posedge clk); #1;
        total++;
        if ({mem_valid, rsp_valid} !== 2'b01) begin
            bad++;
            $display("FAIL wr_rsp_cycle got %b want 01", {mem_valid, rsp_valid});
        end
        wait_rsp(0, rd, er, ls, got, stable);
        total++;
        if ({got, rd, er, ls} !== {1'b1, 32'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL wr_rsp got=%b rdata=%h err=%b last=%b want 1 00000000 0 1", got, rd, er, ls);
        end
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL wr_idle got %b want 10", {cmd_ready, busy});
        end
        total++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h03000004 || q_wdata[0] !== 32'h00000001 ||
            q_wstrb[0] !== 4'hF) begin
            bad++;
            $display("FAIL wr_beat got n=%0d addr=%h wdata=%h wstrb=%h want 1 03000004 00000001 f",
                     q_addr.size(), q_addr.size() > 0 ? q_addr[0] : 32'hx,
                     q_wdata.size() > 0 ? q_wdata[0] : 32'hx, q_wstrb.size() > 0 ? q_wstrb[0] : 4'hx);
        end
        $display("single write: rdata=%h err=%b last=%b beats=%0d", rd, er, ls, q_addr.size());
    endtask

    task automatic test_read_burst();
        logic [31:0] rd;
        logic [31:0] exp_addr[4];
        logic er, ls;
        bit got, stable;
        exp_addr[0] = 32'h03000000;
        exp_addr[1] = 32'h03000004;
        exp_addr[2] = 32'h03000008;
        exp_addr[3] = 32'h0300000C;
        clear_log();
        send_cmd(1'b0, 32'h03000000, 32'h12345678, 4'hF, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wait_rsp(2, rd, er, ls, got, stable);
            total++;
            if ({got, stable, rd, er, ls} !==
                {1'b1, 1'b1, exp_addr[i] ^ 32'hA5A5A5A5, 1'b0, (i == 3) ? 1'b1 : 1'b0}) begin
                bad++;
                $display("FAIL burst_rsp%0d got=%b stable=%b rdata=%h err=%b last=%b want 1 1 %h 0 %b",
                         i, got, stable, rd, er, ls, exp_addr[i] ^ 32'hA5A5A5A5, i == 3);
            end
            $display("burst beat %0d: rdata=%h last=%b", i, rd, ls);
        end
        total++;
        if (q_addr.size() != 4) begin
            bad++;
            $display("FAIL burst_count got %0d want 4", q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_addr[i] !== exp_addr[i] || q_wstrb[i] !== 4'h0) begin
                    bad++;
                    $display("FAIL burst_addr%0d got %h/%h want %h/0", i, q_addr[i], q_wstrb[i], exp_addr[i]);
                end
            end
        end
        total++;
        if (overlap_cycles != 0 || valid_cycles != 4 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL burst_bus got overlap=%0d valid=%0d cmd_ready=%b want 0 4 1",
                     overlap_cycles, valid_cycles, cmd_ready);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic [31:0] exp_addr[3];
        logic er, ls;
        bit got, stable;
        exp_addr[0] = 32'hFFFFFFF8;
        exp_addr[1] = 32'hFFFFFFFC;
        exp_addr[2] = 32'h00000000;
        clear_log();
        send_cmd(1'b0, 32'hFFFFFFF8, 32'h0, 4'h0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            wait_rsp(0, rd, er, ls, got, stable);
            total++;
            if ({got, rd, ls} !== {1'b1, exp_addr[i] ^ 32'hA5A5A5A5, (i == 2) ? 1'b1 : 1'b0}) begin
                bad++;
                $display("FAIL wrap_rsp%0d got=%b rdata=%h last=%b want 1 %h %b",
                         i, got, rd, ls, exp_addr[i] ^ 32'hA5A5A5A5, i == 2);
            end
        end
        total++;
        if (q_addr.size() != 3 || q_addr[0] !== exp_addr[0] || q_addr[1] !== exp_addr[1] ||
            q_addr[2] !== exp_addr[2]) begin
            bad++;
            $display("FAIL wrap_addrs got n=%0d last=%h want 3 00000000", q_addr.size(),
                     q_addr.size() > 0 ? q_addr[q_addr.size() - 1] : 32'hx);
        end
        $display("wrap: beats=%0d", q_addr.size());
    endtask

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd;
        logic er, ls;
        bit got, stable;
        clear_log();
        resp_en = 1'b0;
        send_cmd(1'b0, 32'h03000010, 32'h0, 4'h0, 8'd2);
        wait_rsp(0, rd, er, ls, got, stable);
        total++;
        if ({got, rd, er, ls} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL timeout_rsp got=%b rdata=%h err=%b last=%b want 1 00000000 1 1", got, rd, er, ls);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (valid_cycles != 8 || q_addr.size() != 1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_bus got valid=%0d beats=%0d cmd_ready=%b want 8 1 1",
                     valid_cycles, q_addr.size(), cmd_ready);
        end
        $display("timeout: valid_cycles=%0d err=%b", valid_cycles, er);
        resp_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_burst();
        logic [31:0] rd;
        logic er, ls;
        bit got, stable;
        int beats_after;
        bit saw_rsp;
        clear_log();
        resp_en = 1'b1;
        send_cmd(1'b0, 32'h03000100, 32'h0, 4'h0, 8'd3);
        wait_rsp(0, rd, er, ls, got, stable);
        total++;
        if ({got, mem_valid, mem_addr} !== {1'b1, 1'b1, 32'h03000104}) begin
            bad++;
            $display("FAIL rst_second_req got=%b valid=%b addr=%h want 1 1 03000104", got, mem_valid, mem_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({mem_valid, rsp_valid, busy, cmd_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid got %b want 0000", {mem_valid, rsp_valid, busy, cmd_ready});
        end
        rst = 1'b0;
        beats_after = q_addr.size();
        saw_rsp = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid || mem_valid) saw_rsp = 1'b1;
        end
        total++;
        if (saw_rsp || q_addr.size() != beats_after || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_residual got activity=%b beats=%0d cmd_ready=%b want 0 %0d 1",
                     saw_rsp, q_addr.size(), cmd_ready, beats_after);
        end
        send_cmd(1'b0, 32'h00000040, 32'h0, 4'h0, 8'd0);
        wait_rsp(1, rd, er, ls, got, stable);
        total++;
        if ({got, stable, rd, er, ls} !== {1'b1, 1'b1, 32'h000000040 ^ 32'hA5A5A5A5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_new_read got=%b stable=%b rdata=%h err=%b last=%b want 1 1 a5a5a5e5 0 1",
                     got, stable, rd, er, ls);
        end
        $display("reset mid-burst: new read rdata=%h last=%b", rd, ls);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resp_en    = 1'b1;
        prev_valid = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 32'd0;
        cmd_wdata  = 32'd0;
        cmd_wstrb  = 4'd0;
        cmd_len    = 8'd0;
        rsp_ready  = 1'b0;
        rst        = 1'b1;
        clear_log();
        test_reset();
        test_single_write();
        test_read_burst();
        test_wrap();
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
